// File: rtl/fifo_serial.sv
// Serialises one stereo pixel sample into a COORD word followed by a PIX word
// for the cross-domain stream FIFO that feeds fifo_deserial.
module fifo_serial #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [7:0]  pix_left,
  input  logic [7:0]  pix_right,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [31:0] fifo_data,
  output logic [15:0] pkt_count,
  output logic [7:0]  drop_count,
  output logic [5:0]  debug_out
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SEND_COORD = 2'b01,
    SEND_PIX   = 2'b10
  } state_t;

  localparam logic [10:0] C_FRAME_W = 11'(FRAME_W);
  localparam logic [10:0] C_FRAME_H = 11'(FRAME_H);

  state_t      r_state;
  state_t      w_nextState;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [7:0]  r_left;
  logic [7:0]  r_right;
  logic [15:0] r_pktCount;
  logic [7:0]  r_dropCount;

  logic        w_ready;
  logic        w_transfer;
  logic        w_inRange;
  logic        w_pktDone;
  logic        w_drop;
  logic [31:0] w_coordWord;
  logic [31:0] w_pixWord;

  // A new sample may be taken in IDLE or on the same edge the PIX word leaves.
  assign w_ready    = (r_state == IDLE) | ((r_state == SEND_PIX) & ~fifo_full);
  assign w_transfer = pix_valid & w_ready;
  assign w_inRange  = ({1'b0, pix_x} < C_FRAME_W) & ({1'b0, pix_y} < C_FRAME_H);
  assign w_drop     = w_transfer & ~w_inRange;

  assign w_coordWord = {1'b0, 5'b0, r_y, 6'b0, r_x};
  assign w_pixWord   = {1'b1, 15'b0, r_left, r_right};

  always_comb begin
    w_nextState = r_state;
    fifo_wrreq  = 1'b0;
    fifo_data   = 32'h0;
    w_pktDone   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_transfer && w_inRange) w_nextState = SEND_COORD;
      end
      SEND_COORD: begin
        fifo_data = w_coordWord;
        if (!fifo_full) begin
          fifo_wrreq  = 1'b1;
          w_nextState = SEND_PIX;
        end
      end
      SEND_PIX: begin
        fifo_data = w_pixWord;
        if (!fifo_full) begin
          fifo_wrreq  = 1'b1;
          w_pktDone   = 1'b1;
          w_nextState = (w_transfer && w_inRange) ? SEND_COORD : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Out-of-range samples are captured too; fifo_data only reads them from SEND_* states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_left  <= '0;
      r_right <= '0;
    end else if (w_transfer) begin
      r_x     <= pix_x;
      r_y     <= pix_y;
      r_left  <= pix_left;
      r_right <= pix_right;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pktCount  <= '0;
      r_dropCount <= '0;
    end else begin
      if (w_pktDone) r_pktCount <= r_pktCount + 16'd1;
      if (w_drop && (r_dropCount != 8'hFF)) r_dropCount <= r_dropCount + 8'd1;
    end
  end

  assign pix_ready  = w_ready;
  assign pkt_count  = r_pktCount;
  assign drop_count = r_dropCount;
  assign debug_out  = {fifo_full, pix_valid, w_ready, fifo_wrreq, r_state};

endmodule

// File: tb/tb_fifo_serial.sv
// Directed bench for fifo_serial: word formats, latency, back-to-back, stalls,
// range drops, async reset and a randomly stalled stream.
module tb_fifo_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [7:0]  pix_left = '0;
  logic [7:0]  pix_right = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wrreq;
  logic [31:0] fifo_data;
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;
  logic [5:0]  debug_out;

  int checksTotal = 0;
  int checksPassed = 0;
  int expPkt = 0;
  int expDrop = 0;
  int fullWriteCount = 0;
  logic [31:0] wrLog[$];

  fifo_serial dut (
    .clk(clk), .reset(reset),
    .pix_x(pix_x), .pix_y(pix_y), .pix_left(pix_left), .pix_right(pix_right),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .pkt_count(pkt_count), .drop_count(drop_count), .debug_out(debug_out)
  );

  always #5 clk = ~clk;

  // Record every word the FIFO would accept at the following rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_wrreq) wrLog.push_back(fifo_data);
      if (fifo_wrreq && fifo_full) fullWriteCount++;
    end
  end

  function automatic logic [31:0] coordWord(input int x, input int y);
    logic [9:0] xv;
    logic [9:0] yv;
    xv = 10'(x);
    yv = 10'(y);
    return {6'b0, yv, 6'b0, xv};
  endfunction

  function automatic logic [31:0] pixWord(input int l, input int r);
    logic [7:0] lv;
    logic [7:0] rv;
    lv = 8'(l);
    rv = 8'(r);
    return {1'b1, 15'b0, lv, rv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int l, input int r);
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_left  = 8'(l);
    pix_right = 8'(r);
  endtask

  task automatic test_reset();
    checksTotal++;
    if (pix_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", pix_ready);
    else checksPassed++;
    checksTotal++;
    if (fifo_wrreq !== 1'b0) $display("[TB] FAIL reset_wrreq: got %b expected 0", fifo_wrreq);
    else checksPassed++;
    checksTotal++;
    if (fifo_data !== 32'h0) $display("[TB] FAIL reset_data: got %h expected 00000000", fifo_data);
    else checksPassed++;
    checksTotal++;
    if (pkt_count !== 16'h0) $display("[TB] FAIL reset_pkt: got %h expected 0000", pkt_count);
    else checksPassed++;
    checksTotal++;
    if (drop_count !== 8'h0) $display("[TB] FAIL reset_drop: got %h expected 00", drop_count);
    else checksPassed++;
    checksTotal++;
    if (debug_out[1:0] !== 2'b00) $display("[TB] FAIL reset_state: got %b expected 00", debug_out[1:0]);
    else checksPassed++;
  endtask

  task automatic test_single();
    drive(5, 7, 8'hAA, 8'h55);
    pix_valid = 1'b1;
    #1;
    checksTotal++;
    if (pix_ready !== 1'b1) $display("[TB] FAIL single_ready_idle: got %b expected 1", pix_ready);
    else checksPassed++;
    tick();
    pix_valid = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    checksTotal++;
    if (fifo_wrreq !== 1'b1 || fifo_data !== 32'h0007_0005)
      $display("[TB] FAIL single_coord: got wrreq=%b data=%h expected 1 00070005", fifo_wrreq, fifo_data);
    else checksPassed++;
    checksTotal++;
    if (pix_ready !== 1'b0) $display("[TB] FAIL single_ready_coord: got %b expected 0", pix_ready);
    else checksPassed++;
    tick();
    checksTotal++;
    if (fifo_wrreq !== 1'b1 || fifo_data !== 32'h8000_AA55)
      $display("[TB] FAIL single_pix: got wrreq=%b data=%h expected 1 8000aa55", fifo_wrreq, fifo_data);
    else checksPassed++;
    tick();
    expPkt = 1;
    checksTotal++;
    if (pkt_count !== 16'(expPkt)) $display("[TB] FAIL single_pkt: got %0d expected %0d", pkt_count, expPkt);
    else checksPassed++;
    checksTotal++;
    if (fifo_wrreq !== 1'b0 || debug_out[1:0] !== 2'b00)
      $display("[TB] FAIL single_idle: got wrreq=%b state=%b expected 0 00", fifo_wrreq, debug_out[1:0]);
    else checksPassed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [16];
    int base;
    int acc;
    int cyc;
    int firstAcc;
    int lastAcc;
    int wrHigh;
    base = wrLog.size();
    for (int k = 0; k < 8; k++) begin
      exp[2*k]   = coordWord(10*k + 1, 20 + k);
      exp[2*k+1] = pixWord(k, 8'hF0 + k);
    end
    acc = 0; cyc = 0; firstAcc = -1; lastAcc = -1; wrHigh = 0;
    while (acc < 8 && cyc < 40) begin
      drive(10*acc + 1, 20 + acc, acc, 8'hF0 + acc);
      pix_valid = 1'b1;
      #1;
      if (cyc >= 1 && fifo_wrreq === 1'b1) wrHigh++;
      if (pix_ready === 1'b1) begin
        if (firstAcc < 0) firstAcc = cyc;
        lastAcc = cyc;
        acc++;
      end
      tick();
      cyc++;
    end
    pix_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (fifo_wrreq === 1'b1) wrHigh++;
      tick();
    end
    tick();
    expPkt += 8;
    checksTotal++;
    if (acc != 8 || lastAcc - firstAcc != 14)
      $display("[TB] FAIL b2b_accepts: got %0d accepts span %0d expected 8 span 14", acc, lastAcc - firstAcc);
    else checksPassed++;
    checksTotal++;
    if (wrHigh != 16) $display("[TB] FAIL b2b_wrreq_cycles: got %0d expected 16", wrHigh);
    else checksPassed++;
    checksTotal++;
    if (wrLog.size() - base != 16) $display("[TB] FAIL b2b_word_count: got %0d expected 16", wrLog.size() - base);
    else checksPassed++;
    for (int i = 0; i < 16; i++) begin
      if (base + i < wrLog.size()) begin
        checksTotal++;
        if (wrLog[base + i] !== exp[i]) $display("[TB] FAIL b2b_word%0d: got %h expected %h", i, wrLog[base + i], exp[i]);
        else checksPassed++;
      end
    end
    checksTotal++;
    if (pkt_count !== 16'(expPkt)) $display("[TB] FAIL b2b_pkt: got %0d expected %0d", pkt_count, expPkt);
    else checksPassed++;
  endtask

  task automatic test_stall();
    int base;
    int stallErr;
    logic [31:0] c;
    logic [31:0] p;
    base = wrLog.size();
    stallErr = 0;
    c = 32'h00C8_0064;
    p = 32'h8000_1234;
    drive(100, 200, 8'h12, 8'h34);
    pix_valid = 1'b1;
    tick();
    drive(1, 1, 1, 1);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (fifo_wrreq !== 1'b0 || fifo_data !== c || pix_ready !== 1'b0) stallErr++;
      tick();
    end
    fifo_full = 1'b0;
    #1;
    if (fifo_wrreq !== 1'b1 || fifo_data !== c) stallErr++;
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (fifo_wrreq !== 1'b0 || fifo_data !== p || pix_ready !== 1'b0) stallErr++;
      tick();
    end
    pix_valid = 1'b0;
    fifo_full = 1'b0;
    #1;
    if (fifo_wrreq !== 1'b1 || fifo_data !== p) stallErr++;
    tick();
    expPkt += 1;
    checksTotal++;
    if (stallErr != 0) $display("[TB] FAIL stall_cycles: got %0d bad cycles expected 0", stallErr);
    else checksPassed++;
    checksTotal++;
    if (wrLog.size() - base != 2 || wrLog[wrLog.size()-2] !== c || wrLog[wrLog.size()-1] !== p)
      $display("[TB] FAIL stall_words: got %0d words last %h expected 2 words %h %h",
               wrLog.size() - base, wrLog[wrLog.size()-1], c, p);
    else checksPassed++;
    checksTotal++;
    if (pkt_count !== 16'(expPkt) || debug_out[1:0] !== 2'b00)
      $display("[TB] FAIL stall_end: got pkt=%0d state=%b expected %0d 00", pkt_count, debug_out[1:0], expPkt);
    else checksPassed++;
  endtask

  task automatic test_range();
    int base;
    base = wrLog.size();
    drive(640, 0, 8'h11, 8'h22);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    expDrop = 1;
    checksTotal++;
    if (drop_count !== 8'(expDrop) || wrLog.size() != base)
      $display("[TB] FAIL range_x640: got drop=%0d words=%0d expected 1 0", drop_count, wrLog.size() - base);
    else checksPassed++;
    drive(639, 479, 8'h3C, 8'hC3);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    expPkt += 1;
    checksTotal++;
    if (wrLog.size() - base != 2 || wrLog[base] !== 32'h01DF_027F || wrLog[base+1] !== 32'h8000_3CC3)
      $display("[TB] FAIL range_corner: got %0d words first %h expected 2 words 01df027f 80003cc3",
               wrLog.size() - base, (wrLog.size() > base) ? wrLog[base] : 32'h0);
    else checksPassed++;
    checksTotal++;
    if (drop_count !== 8'(expDrop) || pkt_count !== 16'(expPkt))
      $display("[TB] FAIL range_counts: got drop=%0d pkt=%0d expected %0d %0d", drop_count, pkt_count, expDrop, expPkt);
    else checksPassed++;
    base = wrLog.size();
    pix_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) drive(0, 480, i, i);
      else drive(700, 5, i, i);
      tick();
    end
    pix_valid = 1'b0;
    tick();
    expDrop = 255;
    checksTotal++;
    if (drop_count !== 8'(expDrop)) $display("[TB] FAIL range_saturate: got %0d expected %0d", drop_count, expDrop);
    else checksPassed++;
    checksTotal++;
    if (wrLog.size() != base || pkt_count !== 16'(expPkt))
      $display("[TB] FAIL range_no_write: got words=%0d pkt=%0d expected 0 %0d", wrLog.size() - base, pkt_count, expPkt);
    else checksPassed++;
  endtask

  task automatic test_async_reset();
    int base;
    base = wrLog.size();
    drive(3, 4, 5, 6);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checksTotal++;
    if (fifo_wrreq !== 1'b0 || fifo_data !== 32'h0 || pix_ready !== 1'b1)
      $display("[TB] FAIL rst_outputs: got wrreq=%b data=%h ready=%b expected 0 00000000 1", fifo_wrreq, fifo_data, pix_ready);
    else checksPassed++;
    checksTotal++;
    if (pkt_count !== 16'h0 || drop_count !== 8'h0 || debug_out[1:0] !== 2'b00)
      $display("[TB] FAIL rst_state: got pkt=%0d drop=%0d state=%b expected 0 0 00", pkt_count, drop_count, debug_out[1:0]);
    else checksPassed++;
    @(posedge clk);
    #3;
    reset = 1'b0;
    expPkt = 0;
    expDrop = 0;
    tick();
    checksTotal++;
    if (wrLog.size() - base != 1 || wrLog[wrLog.size()-1] !== 32'h0004_0003)
      $display("[TB] FAIL rst_orphan: got %0d words last %h expected 1 00040003", wrLog.size() - base, wrLog[wrLog.size()-1]);
    else checksPassed++;
    base = wrLog.size();
    drive(1, 2, 3, 4);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    expPkt = 1;
    checksTotal++;
    if (wrLog.size() - base != 2 || wrLog[base] !== 32'h0002_0001 || wrLog[base+1] !== 32'h8000_0304)
      $display("[TB] FAIL rst_clean_pair: got %0d words expected 2 words 00020001 80000304", wrLog.size() - base);
    else checksPassed++;
    checksTotal++;
    if (pkt_count !== 16'(expPkt)) $display("[TB] FAIL rst_pkt: got %0d expected %0d", pkt_count, expPkt);
    else checksPassed++;
  endtask

  task automatic test_random_stream();
    logic [31:0] expQ[$];
    int base;
    int x, y, l, r;
    int budget;
    int accepted;
    base = wrLog.size();
    for (int k = 0; k < 30; k++) begin
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
      l = $urandom_range(0, 255);
      r = $urandom_range(0, 255);
      expQ.push_back(coordWord(x, y));
      expQ.push_back(pixWord(l, r));
      if ($urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
        fifo_full = ($urandom_range(0, 2) == 0);
        tick();
      end
      drive(x, y, l, r);
      pix_valid = 1'b1;
      accepted = 0;
      budget = 0;
      while (!accepted && budget < 50) begin
        fifo_full = ($urandom_range(0, 2) == 0);
        #1;
        if (pix_ready === 1'b1) accepted = 1;
        tick();
        budget++;
      end
      if (!accepted) begin
        checksTotal++;
        $display("[TB] FAIL stream_timeout: sample %0d not accepted within 50 cycles", k);
      end
    end
    pix_valid = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checksTotal++;
    if (wrLog.size() - base != expQ.size())
      $display("[TB] FAIL stream_count: got %0d words expected %0d", wrLog.size() - base, expQ.size());
    else checksPassed++;
    for (int i = 0; i < expQ.size(); i++) begin
      if (base + i < wrLog.size()) begin
        checksTotal++;
        if (wrLog[base + i] !== expQ[i]) $display("[TB] FAIL stream_word%0d: got %h expected %h", i, wrLog[base + i], expQ[i]);
        else checksPassed++;
      end
    end
    checksTotal++;
    if (fullWriteCount != 0) $display("[TB] FAIL write_while_full: got %0d expected 0", fullWriteCount);
    else checksPassed++;
  endtask

  initial begin
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    test_single();
    test_back_to_back();
    test_stall();
    test_range();
    test_async_reset();
    test_random_stream();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
